// File: rtl/key_repeat_conditioner.sv
// ---------------------------------------------------------------------------
// key_repeat_conditioner
//
// Turns N raw key-held levels from the PS/2 decoder into one-cycle action
// pulses for game control. Each key gets a press pulse and, when its
// repeat_mask bit is set, delayed auto-repeat (DAS delay, then one repeat
// every ARR ticks). Timing uses a shared, free-running prescaler tick.
//
// Ports:
//   clk          system clock
//   clrn         asynchronous active-low reset
//   key_level    raw key-held levels, asynchronous to clk
//   repeat_mask  1 = key auto-repeats while held, 0 = press pulse only
//   enable       0 = suppress all pulses and return every channel to IDLE
//   key_pulse    one-cycle action pulses (registered)
//   key_held     synchronised (optionally glitch-filtered) key levels
//   tick         one-cycle pulse every TICK_DIV cycles
//
// Optional build macro: KEY_GLITCH_FILTER_EN
//   Adds a 3-deep history after the synchroniser; key_held only changes
//   once the synchroniser output and all history bits agree. This adds
//   3 cycles of latency and rejects level pulses shorter than 4 cycles.
//
// Per-channel states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | key released (or enable low); waiting for a fresh press edge
//   S_DELAY  | press pulse sent; counting DAS ticks before the first repeat
//   S_REPEAT | auto-repeating; one pulse every ARR ticks while held
// ---------------------------------------------------------------------------
module key_repeat_conditioner #(
    parameter int NUM_KEYS  = 5,
    parameter int TICK_DIV  = 100000,
    parameter int DAS_TICKS = 170,
    parameter int ARR_TICKS = 50
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [NUM_KEYS-1:0] key_level,
    input  logic [NUM_KEYS-1:0] repeat_mask,
    input  logic                enable,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                tick
);

    localparam int MAX_TICKS = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int PRE_W     = $clog2(TICK_DIV);

    typedef logic [CNT_W-1:0] cnt_t;
    // One extra bit so the incremented count never wraps before the compare.
    typedef logic [CNT_W:0]   cnt_ext_t;
    typedef logic [PRE_W-1:0] pre_t;

    localparam cnt_ext_t DAS_LIM  = cnt_ext_t'(DAS_TICKS);
    localparam cnt_ext_t ARR_LIM  = cnt_ext_t'(ARR_TICKS);
    localparam cnt_t     DAS_HOLD = cnt_t'(DAS_TICKS);
    localparam pre_t     PRE_LAST = pre_t'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Prescaler: free-running, independent of enable.
    // ------------------------------------------------------------------
    pre_t presc;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + 1'b1;
            tick  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Synchroniser and edge history. These keep running while enable is
    // low so that a key already held when enable rises shows no edge.
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] held_prev;
    logic [NUM_KEYS-1:0] rise;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1     <= '0;
            sync2     <= '0;
            held_prev <= '0;
        end else begin
            sync1     <= key_level;
            sync2     <= sync1;
            held_prev <= key_held;
        end
    end

`ifdef KEY_GLITCH_FILTER_EN
    logic [NUM_KEYS-1:0] hist0;
    logic [NUM_KEYS-1:0] hist1;
    logic [NUM_KEYS-1:0] hist2;
    logic [NUM_KEYS-1:0] all_one;
    logic [NUM_KEYS-1:0] all_zero;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hist0 <= '0;
            hist1 <= '0;
            hist2 <= '0;
        end else begin
            hist0 <= sync2;
            hist1 <= hist0;
            hist2 <= hist1;
        end
    end

    assign all_one  = sync2 & hist0 & hist1 & hist2;
    assign all_zero = ~(sync2 | hist0 | hist1 | hist2);

    // held_prev doubles as the filter's memory: the filtered level only
    // moves when the window is unanimous, otherwise it holds its last value.
    // Resolving the agreement combinationally keeps the added latency to
    // exactly the 3 history stages.
    assign key_held = all_one | (held_prev & ~all_zero);
`else
    assign key_held = sync2;
`endif

    assign rise = key_held & ~held_prev;

    // ------------------------------------------------------------------
    // Per-channel DAS/ARR state machines.
    // ------------------------------------------------------------------
    state_t              st      [NUM_KEYS];
    state_t              st_nxt  [NUM_KEYS];
    cnt_t                cnt     [NUM_KEYS];
    cnt_t                cnt_nxt [NUM_KEYS];
    cnt_ext_t            cnt_inc [NUM_KEYS];
    logic [NUM_KEYS-1:0] pulse_nxt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                st[i]  <= S_IDLE;
                cnt[i] <= '0;
            end
            key_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                st[i]  <= st_nxt[i];
                cnt[i] <= cnt_nxt[i];
            end
            key_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_inc[i] = {1'b0, cnt[i]} + 1'b1;
        end
    end

    always_comb begin
        pulse_nxt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
        end

        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!enable) begin
                st_nxt[i]  = S_IDLE;
                cnt_nxt[i] = '0;
            end else begin
                case (st[i])
                    S_IDLE: begin
                        if (rise[i]) begin
                            pulse_nxt[i] = 1'b1;
                            st_nxt[i]    = S_DELAY;
                            cnt_nxt[i]   = '0;
                        end
                    end

                    S_DELAY: begin
                        // Release is checked first so it beats a same-cycle expiry.
                        if (!key_held[i]) begin
                            st_nxt[i]  = S_IDLE;
                            cnt_nxt[i] = '0;
                        end else if (tick) begin
                            if (cnt_inc[i] >= DAS_LIM) begin
                                if (repeat_mask[i]) begin
                                    pulse_nxt[i] = 1'b1;
                                    st_nxt[i]    = S_REPEAT;
                                    cnt_nxt[i]   = '0;
                                end else begin
                                    // Non-repeating key: park at the limit so the
                                    // counter cannot wrap during a long hold.
                                    cnt_nxt[i] = DAS_HOLD;
                                end
                            end else begin
                                cnt_nxt[i] = cnt_inc[i][CNT_W-1:0];
                            end
                        end
                    end

                    S_REPEAT: begin
                        if (!key_held[i]) begin
                            st_nxt[i]  = S_IDLE;
                            cnt_nxt[i] = '0;
                        end else if (tick) begin
                            if (cnt_inc[i] >= ARR_LIM) begin
                                // Mask is live: a cleared bit silences repeats but
                                // the channel stays here until the key is released.
                                pulse_nxt[i] = repeat_mask[i];
                                cnt_nxt[i]   = '0;
                            end else begin
                                cnt_nxt[i] = cnt_inc[i][CNT_W-1:0];
                            end
                        end
                    end

                    default: begin
                        st_nxt[i]  = S_IDLE;
                        cnt_nxt[i] = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Directed bench for key_repeat_conditioner with NUM_KEYS=5, TICK_DIV=4,
// DAS_TICKS=3, ARR_TICKS=2. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so "cyc" counts edges since
// reset release and a level set at cyc=S is first captured at edge S+1.
module tb_key_repeat_conditioner;

    localparam int NK  = 5;
    localparam int TD  = 4;
    localparam int DAS = 3;
    localparam int ARR = 2;

`ifdef KEY_GLITCH_FILTER_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif
    // Press set at cyc=S -> press pulse seen at cyc S+LAT.
    localparam int LAT = 3 + EXTRA;
    // Press set at cyc=S with S%4==0 -> first repeat pulse seen at S+FIRE_OFF.
    // Ticks are visible at cyc%4==0 and counted on the following edge; the
    // third counted tick after the press pulse fires the repeat.
    localparam int FIRE_OFF = (EXTRA == 0) ? 13 : 17;

    logic          clk;
    logic          clrn;
    logic [NK-1:0] key_level;
    logic [NK-1:0] repeat_mask;
    logic          enable;
    logic [NK-1:0] key_pulse;
    logic [NK-1:0] key_held;
    logic          tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int p[$];
    int other;
    int n_pulse;
    int held_seen;
    int s0;
    int gap;

    key_repeat_conditioner #(
        .NUM_KEYS (NK),
        .TICK_DIV (TD),
        .DAS_TICKS(DAS),
        .ARR_TICKS(ARR)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .key_level  (key_level),
        .repeat_mask(repeat_mask),
        .enable     (enable),
        .key_pulse  (key_pulse),
        .key_held   (key_held),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clrn        = 1'b0;
        key_level   = '0;
        repeat_mask = 5'b00111;
        enable      = 1'b1;

        // ---- reset state ----
        step();
        step();
        check("rst_pulse", 32'(key_pulse), 0);
        check("rst_held",  32'(key_held),  0);
        check("rst_tick",  32'(tick),      0);

        // ---- 1: tick cadence, idle outputs ----
        clrn = 1'b1;
        cyc  = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            check("tick_cadence", 32'(tick), (cyc % 4 == 0) ? 1 : 0);
        end
        check("idle_pulse", 32'(key_pulse), 0);
        check("idle_held",  32'(key_held),  0);

        // ---- 2: key 0 held 40 cycles with repeat ----
        key_level[0] = 1'b1;           // cyc == 12
        p.delete();
        other = 0;
        while (cyc < 60) begin
            step();
            if (key_pulse[0]) p.push_back(cyc);
            if (key_pulse[4:1] != 0) other++;
            if (cyc == 30) check("held_key0", 32'(key_held), 32'h01);
            if (cyc == 52) key_level[0] = 1'b0;
        end
        check("rep_count", p.size(), 5);
        check("rep_other", other, 0);
        if (p.size() == 5) begin
            check("press_latency", p[0], 12 + LAT);
            check("first_repeat",  p[1], 12 + FIRE_OFF);
            gap = p[1] - p[0];
            check("das_window", (gap >= 8 && gap <= 13) ? 1 : 0, 1);
            check("arr_gap1", p[2] - p[1], 8);
            check("arr_gap2", p[3] - p[2], 8);
            check("arr_gap3", p[4] - p[3], 8);
        end

        // ---- 3: key 3 not in repeat mask, held 60 cycles ----
        key_level[3] = 1'b1;
        n_pulse = 0;
        other   = 0;
        for (int n = 0; n < 68; n++) begin
            step();
            if (key_pulse[3]) n_pulse++;
            if ((key_pulse & 5'b10111) != 0) other++;
            if (n == 59) key_level[3] = 1'b0;
        end
        check("nomask_count", n_pulse, 1);
        check("nomask_other", other, 0);

        // ---- 4a: key 1 released one cycle before the repeat expiry ----
        while (cyc % 4 != 0) step();
        s0 = cyc;
        key_level[1] = 1'b1;
        p.delete();
        while (cyc < s0 + FIRE_OFF + 6) begin
            step();
            if (key_pulse[1]) p.push_back(cyc);
            if (cyc == s0 + FIRE_OFF - 4 - EXTRA) key_level[1] = 1'b0;
        end
        check("early_rel_count", p.size(), 1);
        if (p.size() == 1) check("early_rel_press", p[0], s0 + LAT);

        // ---- 4b: release lands exactly in the expiry cycle ----
        while (cyc % 4 != 0) step();
        s0 = cyc;
        key_level[1] = 1'b1;
        p.delete();
        while (cyc < s0 + FIRE_OFF + 6) begin
            step();
            if (key_pulse[1]) p.push_back(cyc);
            if (cyc == s0 + FIRE_OFF - 3 - EXTRA) key_level[1] = 1'b0;
        end
        check("tie_rel_count", p.size(), 1);
        if (p.size() == 1) check("tie_rel_press", p[0], s0 + LAT);

        // ---- 5a: enable dropped for 5 cycles mid-REPEAT, key kept held ----
        while (cyc % 4 != 0) step();
        s0 = cyc;
        key_level[2] = 1'b1;
        p.delete();
        while (cyc < s0 + 60) begin
            step();
            if (key_pulse[2]) p.push_back(cyc);
            if (cyc == s0 + FIRE_OFF + 2) enable = 1'b0;
            if (cyc == s0 + FIRE_OFF + 7) enable = 1'b1;
        end
        check("en_drop_count", p.size(), 2);
        if (p.size() == 2) check("en_drop_last", p[1], s0 + FIRE_OFF);
        check("en_drop_held", 32'(key_held[2]), 1);

        key_level[2] = 1'b0;
        for (int n = 0; n < 8; n++) step();

        // ---- 6: short glitch and a 10-cycle press on key 4 ----
        key_level[4] = 1'b1;
        s0 = cyc;
        n_pulse   = 0;
        held_seen = 0;
        p.delete();
        while (cyc < s0 + 12) begin
            step();
            if (key_pulse[4]) n_pulse++;
            if (key_held[4]) held_seen = 1;
            if (cyc == s0 + 2) key_level[4] = 1'b0;
        end
        check("glitch_pulse", n_pulse,   (EXTRA == 0) ? 1 : 0);
        check("glitch_held",  held_seen, (EXTRA == 0) ? 1 : 0);

        key_level[4] = 1'b1;
        s0 = cyc;
        while (cyc < s0 + 16) begin
            step();
            if (key_pulse[4]) p.push_back(cyc);
            if (cyc == s0 + 10) key_level[4] = 1'b0;
        end
        check("press10_count", p.size(), 1);
        if (p.size() == 1) check("press10_latency", p[0], s0 + LAT);

        // ---- 5b: re-press key 2, then async reset mid-REPEAT ----
        while (cyc % 4 != 0) step();
        s0 = cyc;
        key_level[2] = 1'b1;
        p.delete();
        while (cyc < s0 + FIRE_OFF + 8) begin
            step();
            if (key_pulse[2]) p.push_back(cyc);
        end
        check("repress_count", p.size(), 3);
        check("repress_pulse_now", 32'(key_pulse), 32'h04);
        check("repress_held", 32'(key_held[2]), 1);
        #2;
        clrn = 1'b0;
        #1;
        check("async_rst_pulse", 32'(key_pulse), 0);
        check("async_rst_held",  32'(key_held),  0);
        check("async_rst_tick",  32'(tick),      0);
        key_level = '0;
        step();
        check("rst_hold_pulse", 32'(key_pulse), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_repeat_conditioner.md
Name: key_repeat_conditioner

Overview:
Parametrised successor to the single-shot keyboard-to-game signal path. It takes N raw key levels from the PS/2 decoder, synchronises them, and emits one-cycle action pulses to game control. Per key it adds a Tetris-style delayed auto-repeat (DAS/ARR), with a repeat mask to choose which keys repeat. It sits between KeyboardControl and GameControl, in the same clock domain as GameControl.

Parameters:
NUM_KEYS, 5, number of key channels (bit order left, right, down, up, space in the top level)
TICK_DIV, 100000, clk cycles per repeat-timing tick (1 ms at 100 MHz); must be >= 2
DAS_TICKS, 170, ticks from first press pulse to first repeat pulse; must be >= 1
ARR_TICKS, 50, ticks between subsequent repeat pulses; must be >= 1

Ports:
clk  input  1  system clock
clrn  input  1  asynchronous active-low reset
key_level  input  NUM_KEYS  raw key-held levels, asynchronous to clk
repeat_mask  input  NUM_KEYS  1 = key auto-repeats while held; 0 = press pulse only
enable  input  1  0 = suppress all pulses and return every channel to IDLE
key_pulse  output  NUM_KEYS  one-cycle action pulses, registered
key_held  output  NUM_KEYS  synchronised (filtered) key levels
tick  output  1  one-cycle pulse every TICK_DIV cycles

Behaviour:
- Reset (clrn low, asynchronous): key_pulse=0, key_held=0, tick=0, prescaler=0, all synchroniser and history flops 0, all channels IDLE, all counters 0.
- Synchroniser: 2 flops per key. key_held = second stage. Edge detect compares it with a registered previous copy.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1; tick is registered high for one cycle on wrap.
  - First tick occurs TICK_DIV cycles after reset release.
  - Runs regardless of enable.
- Per-channel FSM, states IDLE, DELAY, REPEAT. Counter width is clog2(max(DAS_TICKS,ARR_TICKS)+1).
  - IDLE: on rising edge of the synced level with enable=1, assert key_pulse for 1 cycle, go to DELAY, counter=0.
  - DELAY: counter +1 on each tick.
    - If repeat_mask=1 and counter reaches DAS_TICKS: pulse, go to REPEAT, counter=0.
    - If repeat_mask=0: stay in DELAY, no further pulses.
  - REPEAT: counter +1 on each tick; when it reaches ARR_TICKS, pulse and set counter=0.
  - Release (synced level 0) in DELAY or REPEAT: go to IDLE, no pulse.
  - Release and counter expiry in the same cycle: release wins, no pulse.
- repeat_mask is sampled live. Clearing it in REPEAT stops further pulses; the channel stays in REPEAT until release.
- enable=0: all channels forced to IDLE, key_pulse=0 next cycle. Synchronisers and edge history keep running. A key already held when enable rises produces no pulse; a fresh press is required.
- Latency: a key_level rise meeting setup before edge k gives key_pulse high in the cycle after edge k+2 (3 edges), for exactly 1 cycle.
- First-repeat timing: ticks are shared and free-running, so the first repeat comes between DAS_TICKS-1 and DAS_TICKS tick periods after the press pulse (plus up to one cycle). Later repeats are exactly ARR_TICKS*TICK_DIV cycles apart.
- Channels are independent; multiple key_pulse bits may assert in the same cycle.

Optional Feature:
KEY_GLITCH_FILTER_EN
- Defined: a 3-deep history register follows the second synchroniser stage. key_held updates only when the sync output and all 3 history bits agree. This adds exactly 3 cycles of latency (pulse 6 edges after input change) and rejects pulses shorter than 4 cycles.
- Undefined: no filter; key_held is the second sync stage; latency is 3 edges.

Test Plan:
1. Parameters NUM_KEYS=5, TICK_DIV=4, DAS_TICKS=3, ARR_TICKS=2. Release clrn, hold all keys 0 -> key_pulse=0, key_held=0; tick first high 4 cycles after reset release, then every 4 cycles.
2. repeat_mask=5'b00111. Raise key_level[0] before edge k and hold 40 cycles -> key_pulse[0] high in the cycle after edge k+2. First repeat 8-12 cycles later, then repeats every 8 cycles. No pulses on other bits.
3. repeat_mask[3]=0. Hold key_level[3] for 60 cycles -> exactly one pulse on key_pulse[3].
4. Press key 1, release 1 cycle before the repeat would fire -> only the initial pulse. Retime the release to land in the expiry cycle -> still no repeat pulse.
5. Hold key 2, drop enable for 5 cycles mid-REPEAT, raise it with the key still held -> no pulses until release and re-press. Assert clrn low mid-REPEAT -> all outputs 0 immediately, asynchronously.
6. KEY_GLITCH_FILTER_EN defined. 2-cycle glitch on key_level[4] -> no pulse, key_held[4] stays 0. 10-cycle press -> pulse in the cycle after edge k+5.
